// File: rtl/inst_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : inst_fetch_ctrl
// Description : Byte-serial instruction fetch sequencer. Reads one byte per
//               cycle from a byte-wide instruction memory, assembles four
//               bytes little-endian into a 32-bit instruction and queues it,
//               with its PC, in a small prefetch FIFO. Decode consumes the
//               FIFO head with a valid/ready handshake. Redirects restart
//               fetch at a new PC and flush all buffered and in-flight work.
// Ports       : clk, reset           - clock, synchronous active-high reset
//               redirect_valid/addr  - one-cycle restart request and new PC
//               mem_rd_en/addr       - registered byte read request
//               mem_rdata            - read data, valid 1 cycle after request
//               inst_valid/ready     - FIFO head handshake
//               inst_out/inst_pc     - instruction and PC at FIFO head
//               fault                - sticky fetch fault (bound/alignment)
// Revision    : 1.0 - initial release
// ============================================================================
module inst_fetch_ctrl #(
    parameter logic [63:0] RESET_PC   = 64'h0,
    parameter int unsigned MEM_BYTES  = 160,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_addr,
    output logic        mem_rd_en,
    output logic [63:0] mem_addr,
    input  logic [7:0]  mem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_out,
    output logic [63:0] inst_pc,
    output logic        fault
);

    localparam int unsigned        C_PTR_W     = $clog2(FIFO_DEPTH);
    localparam int unsigned        C_CNT_W     = C_PTR_W + 1;
    localparam logic [C_CNT_W:0]   C_DEPTH     = (C_CNT_W + 1)'(FIFO_DEPTH);
    localparam logic [63:0]        C_MEM_BYTES = 64'(MEM_BYTES);

    localparam logic [1:0] C_ST_FETCH = 2'd0;
    localparam logic [1:0] C_ST_WAIT  = 2'd1;
    localparam logic [1:0] C_ST_FAULT = 2'd2;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [1:0]         state_q,     state_d;
    logic [1:0]         byte_idx_q,  byte_idx_d;   // next byte of word to issue
    logic [63:0]        fetch_pc_q,  fetch_pc_d;   // base PC of word being issued
    logic               mem_rd_en_q, mem_rd_en_d;
    logic [63:0]        mem_addr_q,  mem_addr_d;
    logic               rsp_valid_q, rsp_valid_d;  // mem_rdata carries a live byte
    logic [63:0]        rsp_addr_q,  rsp_addr_d;   // address that byte came from
    logic [23:0]        asm_q,       asm_d;        // bytes 0..2 of word in assembly
    logic [31:0]        fifo_inst_q [FIFO_DEPTH];
    logic [31:0]        fifo_inst_d [FIFO_DEPTH];
    logic [63:0]        fifo_pc_q   [FIFO_DEPTH];
    logic [63:0]        fifo_pc_d   [FIFO_DEPTH];
    logic [C_PTR_W-1:0] wr_ptr_q,    wr_ptr_d;
    logic [C_PTR_W-1:0] rd_ptr_q,    rd_ptr_d;
    logic [C_CNT_W-1:0] count_q,     count_d;
    // Words started but not yet pushed; they hold a reserved FIFO slot so a
    // word is never issued unless it is guaranteed somewhere to land.
    logic [C_CNT_W-1:0] inflight_q,  inflight_d;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic               w_push;
    logic               w_pop;
    logic [C_CNT_W:0]   w_occ;
    logic               w_room;
    logic               w_word_oob;
    logic               w_redir_bad;
    logic               w_word_start;

    // Words are always aligned, so the low address bits of a response are the
    // byte lane it belongs to; lane 3 completes the word.
    assign w_push      = rsp_valid_q && (rsp_addr_q[1:0] == 2'd3) && !redirect_valid;
    assign w_pop       = (count_q != '0) && inst_ready && !redirect_valid;
    assign w_occ       = {1'b0, count_q} + {1'b0, inflight_q};
    assign w_room      = (w_occ < C_DEPTH);
    assign w_word_oob  = ((fetch_pc_q + 64'd3) >= C_MEM_BYTES);
    assign w_redir_bad = (redirect_addr[1:0] != 2'b00) ||
                         ((redirect_addr + 64'd3) >= C_MEM_BYTES);

    always_comb begin
        state_d      = state_q;
        byte_idx_d   = byte_idx_q;
        fetch_pc_d   = fetch_pc_q;
        mem_rd_en_d  = 1'b0;
        mem_addr_d   = mem_addr_q;
        rsp_valid_d  = mem_rd_en_q;
        rsp_addr_d   = mem_addr_q;
        asm_d        = asm_q;
        fifo_inst_d  = fifo_inst_q;
        fifo_pc_d    = fifo_pc_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        inflight_d   = inflight_q;
        w_word_start = 1'b0;

        // --------------------------------------------------------------------
        // Response side: runs regardless of issue state so that a word whose
        // last byte is in flight when a bound fault hits is still delivered.
        // --------------------------------------------------------------------
        if (rsp_valid_q) begin
            case (rsp_addr_q[1:0])
                2'd0:    asm_d[7:0]   = mem_rdata;
                2'd1:    asm_d[15:8]  = mem_rdata;
                2'd2:    asm_d[23:16] = mem_rdata;
                default: asm_d        = asm_q;
            endcase
        end

        if (w_push) begin
            fifo_inst_d[wr_ptr_q] = {mem_rdata, asm_q};
            fifo_pc_d[wr_ptr_q]   = {rsp_addr_q[63:2], 2'b00};
            wr_ptr_d              = wr_ptr_q + C_PTR_W'(1);
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + C_PTR_W'(1);
        end
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + C_CNT_W'(1);
            2'b01:   count_d = count_q - C_CNT_W'(1);
            default: count_d = count_q;
        endcase

        // --------------------------------------------------------------------
        // Issue side
        // --------------------------------------------------------------------
        case (state_q)
            C_ST_FETCH: begin
                if (byte_idx_q == 2'd0) begin
                    if (w_word_oob) begin
                        state_d = C_ST_FAULT;
                    end else if (w_room) begin
                        mem_rd_en_d  = 1'b1;
                        mem_addr_d   = fetch_pc_q;
                        byte_idx_d   = 2'd1;
                        w_word_start = 1'b1;
                    end else begin
                        state_d = C_ST_WAIT;
                    end
                end else begin
                    mem_rd_en_d = 1'b1;
                    mem_addr_d  = fetch_pc_q + {62'b0, byte_idx_q};
                    byte_idx_d  = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        fetch_pc_d = fetch_pc_q + 64'd4;
                    end
                end
            end
            C_ST_WAIT: begin
                if (w_room) begin
                    state_d = C_ST_FETCH;
                end
            end
            C_ST_FAULT: begin
                state_d = C_ST_FAULT;
            end
            default: begin
                state_d = C_ST_FETCH;
            end
        endcase

        inflight_d = inflight_q + C_CNT_W'(w_word_start) - C_CNT_W'(w_push);

        // --------------------------------------------------------------------
        // Redirect overrides everything: flush the FIFO, abandon the word in
        // assembly and kill the response to this cycle's request. A good
        // target issues its first byte straight away.
        // --------------------------------------------------------------------
        if (redirect_valid) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            rsp_valid_d = 1'b0;
            asm_d       = '0;
            fetch_pc_d  = redirect_addr;
            if (w_redir_bad) begin
                state_d     = C_ST_FAULT;
                mem_rd_en_d = 1'b0;
                byte_idx_d  = 2'd0;
                inflight_d  = '0;
            end else begin
                state_d     = C_ST_FETCH;
                mem_rd_en_d = 1'b1;
                mem_addr_d  = redirect_addr;
                byte_idx_d  = 2'd1;
                inflight_d  = C_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= C_ST_FETCH;
            byte_idx_q  <= 2'd0;
            fetch_pc_q  <= RESET_PC;
            mem_rd_en_q <= 1'b0;
            mem_addr_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_addr_q  <= '0;
            asm_q       <= '0;
            fifo_inst_q <= '{default: '0};
            fifo_pc_q   <= '{default: '0};
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            inflight_q  <= '0;
        end else begin
            state_q     <= state_d;
            byte_idx_q  <= byte_idx_d;
            fetch_pc_q  <= fetch_pc_d;
            mem_rd_en_q <= mem_rd_en_d;
            mem_addr_q  <= mem_addr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_addr_q  <= rsp_addr_d;
            asm_q       <= asm_d;
            fifo_inst_q <= fifo_inst_d;
            fifo_pc_q   <= fifo_pc_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            inflight_q  <= inflight_d;
        end
    end

    assign mem_rd_en  = mem_rd_en_q;
    assign mem_addr   = mem_addr_q;
    assign inst_valid = (count_q != '0);
    assign inst_out   = fifo_inst_q[rd_ptr_q];
    assign inst_pc    = fifo_pc_q[rd_ptr_q];
    assign fault      = (state_q == C_ST_FAULT);

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_inst_fetch_ctrl
// Description : Self-checking bench for inst_fetch_ctrl. A byte memory model
//               answers reads; expected (pc, instruction) pairs are queued as
//               fetch is steered and compared as decode pops them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_fetch_ctrl;

    localparam int MEMB = 160;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] ins;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_addr = 64'h0;
    logic        mem_rd_en;
    logic [63:0] mem_addr;
    logic [7:0]  mem_rdata = 8'h0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst_out;
    logic [63:0] inst_pc;
    logic        fault;

    logic [7:0]  mem [0:MEMB-1];
    exp_t        exp_q [$];
    exp_t        mon_e;
    int          vectors = 0;
    int          miscompares = 0;
    int          bad_req = 0;
    bit          ready_en = 1'b0;

    always #5 clk = ~clk;

    inst_fetch_ctrl #(
        .RESET_PC   (64'h0),
        .MEM_BYTES  (MEMB),
        .FIFO_DEPTH (2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .mem_rd_en      (mem_rd_en),
        .mem_addr       (mem_addr),
        .mem_rdata      (mem_rdata),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_out       (inst_out),
        .inst_pc        (inst_pc),
        .fault          (fault)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] word_at(input logic [63:0] pc);
        logic [7:0] a;
        a = pc[7:0];
        return {mem[a + 8'd3], mem[a + 8'd2], mem[a + 8'd1], mem[a]};
    endfunction

    task automatic push_exp(input logic [63:0] pc);
        exp_t e;
        e.pc  = pc;
        e.ins = word_at(pc);
        exp_q.push_back(e);
    endtask

    // Memory: one-cycle read latency; garbage when idle or out of range.
    always @(posedge clk) begin
        if (mem_rd_en && (mem_addr < 64'(MEMB)))
            mem_rdata <= mem[mem_addr[7:0]];
        else
            mem_rdata <= 8'($urandom);
    end

    always @(negedge clk) begin
        if (!reset && mem_rd_en && (mem_addr >= 64'(MEMB)))
            bad_req++;
    end

    // Decode is only ready while a word is expected.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            inst_ready = ready_en && (exp_q.size() != 0);
        end
    end

    // Scoreboard: every accepted word must match the next expected entry.
    always @(negedge clk) begin
        if (!reset && !redirect_valid && inst_valid && inst_ready) begin
            if (exp_q.size() == 0) begin
                check("extra_word_pc", inst_pc, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                mon_e = exp_q.pop_front();
                check("word_pc", inst_pc, mon_e.pc);
                check("word_data", {32'h0, inst_out}, {32'h0, mon_e.ins});
            end
        end
    end

    task automatic apply_reset(input string tag);
        @(posedge clk);
        #1;
        reset    = 1'b1;
        ready_en = 1'b0;
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        check({tag, "_rd_en"}, {63'h0, mem_rd_en}, 64'h0);
        check({tag, "_addr"},  mem_addr, 64'h0);
        check({tag, "_valid"}, {63'h0, inst_valid}, 64'h0);
        check({tag, "_inst"},  {32'h0, inst_out}, 64'h0);
        check({tag, "_pc"},    inst_pc, 64'h0);
        check({tag, "_fault"}, {63'h0, fault}, 64'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic do_redirect(input logic [63:0] addr);
        @(posedge clk);
        #1;
        redirect_valid = 1'b1;
        redirect_addr  = addr;
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        check(tag, 64'(exp_q.size()), 64'h0);
        exp_q.delete();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int reqs;
        int n;
        exp_t e;

        for (int i = 0; i < MEMB; i++) mem[i] = 8'($urandom);
        mem[0] = 8'h13; mem[1] = 8'h09; mem[2] = 8'h00; mem[3] = 8'h00;
        mem[4] = 8'h93; mem[5] = 8'h09; mem[6] = 8'h50; mem[7] = 8'h00;

        // ---------------- reset, first words, issue timing ----------------
        apply_reset("rst0");
        e.pc = 64'h0; e.ins = 32'h0000_0913; exp_q.push_back(e);
        e.pc = 64'h4; e.ins = 32'h0050_0993; exp_q.push_back(e);
        ready_en = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("c%0d_rd_en", k), {63'h0, mem_rd_en}, 64'h1);
            check($sformatf("c%0d_addr", k), mem_addr, 64'(k - 1));
            if (k == 5)  check("c5_valid",  {63'h0, inst_valid}, 64'h0);
            if (k == 6)  check("c6_valid",  {63'h0, inst_valid}, 64'h1);
            if (k == 10) check("c10_valid", {63'h0, inst_valid}, 64'h1);
        end

        // ---------------- redirect while byte 2 of pc 8 in flight ---------
        do_redirect(64'h24);
        push_exp(64'h24);
        push_exp(64'h28);
        @(negedge clk);
        check("redir_rd_en", {63'h0, mem_rd_en}, 64'h1);
        check("redir_addr",  mem_addr, 64'h24);
        check("redir_valid", {63'h0, inst_valid}, 64'h0);
        wait_drain("redir24_drain", 60);

        // ---------------- misaligned redirect, then recovery --------------
        do_redirect(64'h26);
        @(negedge clk);
        check("mis_fault", {63'h0, fault}, 64'h1);
        check("mis_rd_en", {63'h0, mem_rd_en}, 64'h0);
        check("mis_valid", {63'h0, inst_valid}, 64'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("mis_fault_sticky", {63'h0, fault}, 64'h1);
        check("mis_rd_en_idle", {63'h0, mem_rd_en}, 64'h0);
        do_redirect(64'h28);
        push_exp(64'h28);
        push_exp(64'h2C);
        @(negedge clk);
        check("rec_fault", {63'h0, fault}, 64'h0);
        check("rec_rd_en", {63'h0, mem_rd_en}, 64'h1);
        check("rec_addr",  mem_addr, 64'h28);
        wait_drain("redir28_drain", 60);

        // ---------------- run to end of memory ----------------------------
        do_redirect(64'h90);
        push_exp(64'h90);
        push_exp(64'h94);
        push_exp(64'h98);
        push_exp(64'h9C);
        wait_drain("end_drain", 100);
        n = 0;
        while (!fault && n < 20) begin
            @(posedge clk);
            n++;
        end
        @(negedge clk);
        check("end_fault", {63'h0, fault}, 64'h1);
        check("end_rd_en", {63'h0, mem_rd_en}, 64'h0);
        check("end_no_oob_req", 64'(bad_req), 64'h0);

        // ---------------- backpressure: buffer fills, head holds ----------
        apply_reset("rst1");
        reqs = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (mem_rd_en) reqs++;
            if (k == 12 || k == 20) begin
                check($sformatf("hold%0d_valid", k), {63'h0, inst_valid}, 64'h1);
                check($sformatf("hold%0d_pc", k), inst_pc, 64'h0);
                check($sformatf("hold%0d_inst", k), {32'h0, inst_out}, 64'h913);
            end
        end
        check("wait_rd_en", {63'h0, mem_rd_en}, 64'h0);
        check("wait_req_count", 64'(reqs), 64'd8);
        push_exp(64'h0);
        push_exp(64'h4);
        push_exp(64'h8);
        ready_en = 1'b1;
        wait_drain("resume_drain", 60);

        // ---------------- reset with full buffer, and mid-word ------------
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("full_valid", {63'h0, inst_valid}, 64'h1);
        apply_reset("rst_full");
        @(posedge clk);
        @(negedge clk);
        check("restart_rd_en", {63'h0, mem_rd_en}, 64'h1);
        check("restart_addr", mem_addr, 64'h0);
        repeat (4) @(posedge clk);
        apply_reset("rst_mid");
        push_exp(64'h0);
        ready_en = 1'b1;
        wait_drain("post_reset_drain", 40);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
